sme_pattern_decoder: RTL and testbench
======================================

// Module: sme_pattern_decoder
// PURPOSE
//  Upstream pre-decode stage for the string-matching engine: captures the serial
//  pattern stream (chardata while ispattern=1), strips '^'/'$' anchors, builds a
//  per-position '.' wildcard mask and body length, and hands one decoded pattern
//  to the matcher over a valid/ready handshake. The matcher does no anchor parsing.
// PARAMETERS
//  MAX_PAT  8   max body characters stored (anchors excluded)
//  DW       8   character width in bits
// PORTS
//  clk            in   1            clock, rising edge
//  reset          in   1            reset, asynchronous, active-high
//  chardata       in   DW           pattern character, sampled when ispattern=1
//  ispattern      in   1            high for contiguous cycles, one char per cycle
//  pat_ready      in   1            matcher accepts the decoded pattern
//  pat_valid      out  1            decoded pattern held, stable until accepted
//  pat_chars      out  DW*MAX_PAT   body chars; entry i at [DW*i +: DW]; unused = 0
//  pat_len        out  4            body length 0..MAX_PAT
//  pat_wild       out  MAX_PAT      bit i = 1 when body char i is '.' (0x2E)
//  anchor_head    out  1            pattern began with '^' (0x5E)
//  anchor_tail    out  1            pattern ended with '$' (0x24)
//  pat_err        out  1            body exceeded MAX_PAT; valid with pat_valid
//  pat_drop       out  1            1-cycle pulse: held pattern discarded unaccepted
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; buffer, counters, flags cleared. Reset during
//   LOAD or HOLD abandons the pattern; no handshake occurs.
//  States: IDLE -> LOAD (ispattern=1) -> HOLD (ispattern=0) -> IDLE (pat_ready=1).
//  LOAD, per char at raw position r (0-based, counting every char incl. anchors):
//   - r=0 and char=0x5E: set head flag, not stored. '^' anywhere else is literal.
//   - Otherwise store at body index b (if b<MAX_PAT), b+=1 (saturates at MAX_PAT+2).
//   - last_char register tracks the most recent char.
//  LOAD exit (edge sampling ispattern=0), same edge:
//   - last_char=0x24 and b>0: anchor_tail=1, pat_len=b-1; that '$' entry is zeroed
//     and its wild bit cleared. '$' not in final position is literal.
//   - pat_err=1 when effective body length > MAX_PAT; pat_len then = MAX_PAT, first
//     MAX_PAT body chars kept. "^abcdefgh$" with MAX_PAT=8 is legal, err=0.
//   - pat_wild[i] = (pat_chars[i]==0x2E) for i<pat_len, else 0.
//   - pat_valid=1 from the cycle after that edge (1-cycle decode latency).
//  HOLD: outputs frozen. Handshake completes on any edge with pat_valid&pat_ready;
//   pat_valid=0 and all pattern outputs zeroed on the following cycle.
//  Simultaneous pat_ready=1 and ispattern=1 in HOLD: handshake completes and the
//   sampled char is taken as r=0 of a new pattern (go to LOAD, no dropped char).
//  ispattern=1 in HOLD with pat_ready=0: held pattern discarded, pat_drop pulses
//   for 1 cycle, the char starts a new LOAD as r=0.
//  Empty pattern (single '^', or '^$'): pat_len=0, pat_err=0, pat_valid asserted.
//  ispattern glitch of one cycle = 1-char pattern; no minimum length.
//  pat_ready ignored in IDLE/LOAD. chardata ignored when ispattern=0.
// TESTING
//  "ab.c" (4 cyc) -> pat_valid 1 cycle after ispattern falls; len=4,
//   wild=8'b0000_0100, head=0, tail=0, chars[0]=0x61.
//  "^a$b$" -> head=1, tail=1, len=3, chars="a$b", wild=0; "$" mid-pattern literal.
//  "^abcdefgh$" -> len=8, err=0, head=tail=1; "abcdefghij" -> len=8, err=1,
//   chars="abcdefgh".
//  Hold pattern with pat_ready=0, then start "xy": pat_drop pulse 1 cycle, new
//   pattern len=2; with pat_ready=1 on that same edge: no pat_drop, both handed over.
//  Assert reset mid-LOAD after 3 chars -> all outputs 0 immediately; next "q"
//   yields len=1, head=0.
//  Single-cycle "^" -> len=0, head=1, pat_valid=1 until pat_ready.

Source files
------------

// File: rtl/sme_pattern_decoder_if.sv
// Bus between the pattern decoder and its neighbours.
// The upstream side supplies the raw pattern stream.
// The matcher side receives the decoded pattern over a valid/ready handshake.
// The decoder is the master of the decoded-pattern transfer.
interface sme_pattern_decoder_if #(
    parameter int DW      = 8,
    parameter int MAX_PAT = 8
);
    logic [DW-1:0]         chardata;
    logic                  ispattern;
    logic                  pat_ready;
    logic                  pat_valid;
    logic [DW*MAX_PAT-1:0] pat_chars;
    logic [3:0]            pat_len;
    logic [MAX_PAT-1:0]    pat_wild;
    logic                  anchor_head;
    logic                  anchor_tail;
    logic                  pat_err;
    logic                  pat_drop;

    modport master (
        input  chardata,
        input  ispattern,
        input  pat_ready,
        output pat_valid,
        output pat_chars,
        output pat_len,
        output pat_wild,
        output anchor_head,
        output anchor_tail,
        output pat_err,
        output pat_drop
    );

    modport slave (
        output chardata,
        output ispattern,
        output pat_ready,
        input  pat_valid,
        input  pat_chars,
        input  pat_len,
        input  pat_wild,
        input  anchor_head,
        input  anchor_tail,
        input  pat_err,
        input  pat_drop
    );
endinterface

// File: rtl/sme_pattern_decoder.sv
// Pre-decode stage for the string-matching engine.
// It captures a serial pattern and strips a leading '^' and a trailing '$'.
// It builds the '.' wildcard mask and the body length.
// It then holds one decoded pattern until the matcher accepts it.
module sme_pattern_decoder #(
    parameter int MAX_PAT = 8,
    parameter int DW      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    sme_pattern_decoder_if.master bus
);

    // The body counter must reach MAX_PAT+2 so that an over-long body
    // followed by a '$' still reports an error after the anchor is removed.
    localparam int CW = $clog2(MAX_PAT + 3);
    localparam logic [CW-1:0] CNT_SAT  = CW'(MAX_PAT + 2);
    localparam logic [CW-1:0] CNT_BODY = CW'(MAX_PAT);

    localparam logic [DW-1:0] CH_HEAD = DW'(8'h5E);
    localparam logic [DW-1:0] CH_TAIL = DW'(8'h24);
    localparam logic [DW-1:0] CH_WILD = DW'(8'h2E);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]    state;
    logic [DW-1:0] body_buf [MAX_PAT];
    logic [CW-1:0] body_cnt;
    logic [DW-1:0] last_char;
    logic          head_flag;

    logic          start_char;
    logic          more_char;
    logic          load_exit;
    logic          release_hold;
    logic          discard;

    logic                  tail_hit;
    logic [CW-1:0]         eff_len;
    logic [CW-1:0]         dec_len;
    logic                  dec_err;
    logic [DW*MAX_PAT-1:0] dec_chars;
    logic [MAX_PAT-1:0]    dec_wild;

    // Classify this cycle's event.
    // A char arriving in IDLE or HOLD always opens a new pattern at raw position 0.
    always_comb begin
        start_char   = bus.ispattern && ((state == ST_IDLE) || (state == ST_HOLD));
        more_char    = bus.ispattern && (state == ST_LOAD);
        load_exit    = !bus.ispattern && (state == ST_LOAD);
        release_hold = (state == ST_HOLD) && (bus.ispattern || bus.pat_ready);
        discard      = (state == ST_HOLD) && bus.ispattern && !bus.pat_ready;
    end

    // Decode the captured body.
    // A trailing '$' is dropped from the length, overflow is clamped and flagged,
    // and entries beyond the final length are forced to zero.
    always_comb begin
        tail_hit  = (last_char == CH_TAIL) && (body_cnt != '0);
        eff_len   = tail_hit ? (body_cnt - CW'(1)) : body_cnt;
        dec_err   = (eff_len > CNT_BODY);
        dec_len   = dec_err ? CNT_BODY : eff_len;
        dec_chars = '0;
        dec_wild  = '0;
        for (int i = 0; i < MAX_PAT; i++) begin
            if (CW'(i) < dec_len) begin
                dec_chars[DW*i +: DW] = body_buf[i];
                dec_wild[i]           = (body_buf[i] == CH_WILD);
            end
        end
    end

    // Sequence the pattern lifecycle: IDLE, then LOAD while chars stream in, then HOLD until taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.ispattern) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!bus.ispattern) begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.ispattern) begin
                        state <= ST_LOAD;
                    end else if (bus.pat_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Capture the stream.
    // A '^' in the first position sets the head flag and is not stored.
    // Every other char is stored until the buffer is full.
    // The body counter keeps counting (saturating) so overflow stays visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            body_cnt  <= '0;
            last_char <= '0;
            head_flag <= 1'b0;
            for (int i = 0; i < MAX_PAT; i++) begin
                body_buf[i] <= '0;
            end
        end else if (start_char) begin
            last_char <= bus.chardata;
            if (bus.chardata == CH_HEAD) begin
                head_flag <= 1'b1;
                body_cnt  <= '0;
            end else begin
                head_flag   <= 1'b0;
                body_buf[0] <= bus.chardata;
                body_cnt    <= CW'(1);
            end
        end else if (more_char) begin
            last_char <= bus.chardata;
            for (int i = 0; i < MAX_PAT; i++) begin
                if (body_cnt == CW'(i)) begin
                    body_buf[i] <= bus.chardata;
                end
            end
            if (body_cnt != CNT_SAT) begin
                body_cnt <= body_cnt + CW'(1);
            end
        end
    end

    // Present the decoded pattern from the cycle after the stream ends.
    // It is frozen through HOLD and cleared once it is accepted or replaced.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.pat_valid   <= 1'b0;
            bus.pat_chars   <= '0;
            bus.pat_len     <= '0;
            bus.pat_wild    <= '0;
            bus.anchor_head <= 1'b0;
            bus.anchor_tail <= 1'b0;
            bus.pat_err     <= 1'b0;
            bus.pat_drop    <= 1'b0;
        end else begin
            bus.pat_drop <= discard;
            if (load_exit) begin
                bus.pat_valid   <= 1'b1;
                bus.pat_chars   <= dec_chars;
                bus.pat_len     <= 4'(dec_len);
                bus.pat_wild    <= dec_wild;
                bus.anchor_head <= head_flag;
                bus.anchor_tail <= tail_hit;
                bus.pat_err     <= dec_err;
            end else if (release_hold) begin
                bus.pat_valid   <= 1'b0;
                bus.pat_chars   <= '0;
                bus.pat_len     <= '0;
                bus.pat_wild    <= '0;
                bus.anchor_head <= 1'b0;
                bus.anchor_tail <= 1'b0;
                bus.pat_err     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sme_pattern_decoder.sv
// Testbench for sme_pattern_decoder.
// The stimulus side pushes the expected decode of every pattern into a queue.
// A monitor pops each entry when the DUT presents a pattern and compares it.
module tb_sme_pattern_decoder;

    localparam int DW      = 8;
    localparam int MAX_PAT = 8;

    typedef struct packed {
        logic [63:0] chars;
        logic [3:0]  len;
        logic [7:0]  wild;
        logic        head;
        logic        tail;
        logic        err;
        logic        dropped;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    sme_pattern_decoder_if #(.DW(DW), .MAX_PAT(MAX_PAT)) bus ();

    sme_pattern_decoder #(.MAX_PAT(MAX_PAT), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    int   checks    = 0;
    int   errors    = 0;
    int   exp_drops = 0;
    int   obs_drops = 0;
    int   pending   = -1;
    exp_t exp_q[$];
    logic [7:0] pat_buf [16];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Reference decode, computed directly from the anchor, length and wildcard rules.
    function automatic exp_t model(input int n);
        exp_t e;
        int   start;
        int   blen;
        e     = '0;
        start = 0;
        if (n > 0 && pat_buf[0] == 8'h5E) begin
            e.head = 1'b1;
            start  = 1;
        end
        blen = n - start;
        if (blen > 0 && pat_buf[n-1] == 8'h24) begin
            e.tail = 1'b1;
            blen--;
        end
        e.err = (blen > MAX_PAT);
        if (blen > MAX_PAT) blen = MAX_PAT;
        e.len = 4'(blen);
        for (int i = 0; i < blen; i++) begin
            e.chars[8*i +: 8] = pat_buf[start+i];
            e.wild[i]         = (pat_buf[start+i] == 8'h2E);
        end
        return e;
    endfunction

    function automatic int set_pattern(input string s);
        for (int i = 0; i < s.len(); i++) pat_buf[i] = s[i];
        return s.len();
    endfunction

    // Stream n chars from pat_buf.
    // The first char also carries the pat_ready decision for a pattern still in HOLD.
    task automatic drive_chars(input int n);
        for (int i = 0; i < n; i++) begin
            bus.ispattern = 1'b1;
            bus.chardata  = pat_buf[i];
            if (i == 0 && pending == 1)      bus.pat_ready = 1'b1;
            else if (i == 0 && pending == 2) bus.pat_ready = 1'b0;
            else                             bus.pat_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        pending       = -1;
        bus.ispattern = 1'b0;
        bus.pat_ready = 1'b0;
        bus.chardata  = 8'($urandom);
        checkOutput("valid_before_exit", bus.pat_valid, 1'b0);
    endtask

    // The mode decides how the pattern ends.
    // 0: accepted by pat_ready. 1: accepted together with the next pattern's first char.
    // 2: discarded by the next pattern. 3: left in HOLD for the caller.
    task automatic applyStimulus(input int n, input int mode, input int gap);
        exp_t e;
        e         = model(n);
        e.dropped = (mode == 2);
        exp_q.push_back(e);
        if (mode == 2) exp_drops++;
        drive_chars(n);
        @(posedge clk); #1;
        checkOutput("valid_latency", bus.pat_valid, 1'b1);
        for (int g = 1; g < gap; g++) begin
            bus.chardata = 8'($urandom);
            @(posedge clk); #1;
        end
        if (mode == 0) begin
            bus.pat_ready = 1'b1;
            @(posedge clk); #1;
            bus.pat_ready = 1'b0;
            checkOutput("valid_after_accept", bus.pat_valid, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                bus.pat_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            bus.pat_ready = 1'b0;
        end else if (mode == 1 || mode == 2) begin
            pending = mode;
        end
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        #2;
        checkOutput("reset_valid", bus.pat_valid, 1'b0);
        checkOutput("reset_chars", bus.pat_chars, 64'h0);
        checkOutput("reset_misc", {bus.pat_len, bus.pat_wild, bus.anchor_head,
                                   bus.anchor_tail, bus.pat_err, bus.pat_drop}, 64'h0);
        bus.ispattern = 1'b0;
        bus.pat_ready = 1'b0;
        @(posedge clk); #1;
        reset   = 1'b0;
        pending = -1;
    endtask

    // Monitor: pop the expectation when a pattern appears and compare it on every held cycle.
    // Require all pattern outputs to be zero when nothing is held.
    // Each pat_drop must belong to a pattern the stimulus meant to discard.
    initial begin
        exp_t cur;
        logic held;
        cur  = '0;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held = 1'b0;
            end else begin
                if (bus.pat_valid) begin
                    if (!held) begin
                        held = 1'b1;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpected_valid actual=1 expected=0");
                            cur = '0;
                        end else begin
                            cur = exp_q.pop_front();
                        end
                    end
                    checkOutput("pat_len",     bus.pat_len,     cur.len);
                    checkOutput("pat_chars",   bus.pat_chars,   cur.chars);
                    checkOutput("pat_wild",    bus.pat_wild,    cur.wild);
                    checkOutput("anchor_head", bus.anchor_head, cur.head);
                    checkOutput("anchor_tail", bus.anchor_tail, cur.tail);
                    checkOutput("pat_err",     bus.pat_err,     cur.err);
                end else begin
                    held = 1'b0;
                    checkOutput("idle_chars", bus.pat_chars, 64'h0);
                    checkOutput("idle_fields", {bus.pat_len, bus.pat_wild, bus.anchor_head,
                                                bus.anchor_tail, bus.pat_err}, 64'h0);
                end
                if (bus.pat_drop) begin
                    obs_drops++;
                    checkOutput("drop_expected", cur.dropped, 1'b1);
                end
            end
        end
    end

    // Stimulus: directed cases first, then randomized patterns.
    initial begin
        int n;
        int mode;
        int gap;
        reset         = 1'b1;
        bus.chardata  = '0;
        bus.ispattern = 1'b0;
        bus.pat_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("init_valid", bus.pat_valid, 1'b0);
        checkOutput("init_misc", {bus.pat_len, bus.pat_wild, bus.anchor_head,
                                  bus.anchor_tail, bus.pat_err, bus.pat_drop}, 64'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        n = set_pattern("ab.c");       applyStimulus(n, 0, 2);
        n = set_pattern("^a$b$");      applyStimulus(n, 0, 1);
        n = set_pattern("^abcdefgh$"); applyStimulus(n, 0, 2);
        n = set_pattern("abcdefghij"); applyStimulus(n, 0, 1);
        n = set_pattern("abcdefghi$"); applyStimulus(n, 0, 1);
        n = set_pattern("^");          applyStimulus(n, 0, 4);
        n = set_pattern("$");          applyStimulus(n, 0, 1);
        n = set_pattern("^$");         applyStimulus(n, 0, 1);
        n = set_pattern("x^.^");       applyStimulus(n, 0, 1);

        n = set_pattern("mno");        applyStimulus(n, 2, 2);
        n = set_pattern("xy");         applyStimulus(n, 1, 2);
        n = set_pattern("k");          applyStimulus(n, 0, 1);

        n = set_pattern("^ab");
        for (int i = 0; i < 3; i++) begin
            bus.ispattern = 1'b1;
            bus.chardata  = pat_buf[i];
            @(posedge clk); #1;
        end
        pulseReset();
        n = set_pattern("q");          applyStimulus(n, 0, 1);

        n = set_pattern("^zz.$");      applyStimulus(n, 3, 2);
        pulseReset();
        n = set_pattern("a.b");        applyStimulus(n, 0, 1);

        for (int it = 0; it < 250; it++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 9))
                    0:       pat_buf[i] = 8'h5E;
                    1:       pat_buf[i] = 8'h24;
                    2:       pat_buf[i] = 8'h2E;
                    default: pat_buf[i] = 8'h61 + 8'($urandom_range(0, 25));
                endcase
            end
            if ($urandom_range(0, 3) == 0) pat_buf[0] = 8'h5E;
            if ($urandom_range(0, 3) == 0) pat_buf[n-1] = 8'h24;
            mode = (it == 249) ? 0 : $urandom_range(0, 2);
            gap  = $urandom_range(1, 3);
            applyStimulus(n, mode, gap);
        end

        repeat (4) @(posedge clk);
        #1;
        checkOutput("queue_empty", exp_q.size(), 0);
        checkOutput("drop_count", obs_drops, exp_drops);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
